// File: rtl/avalon_bus_ctrl.sv
// Avalon-MM master bridging an instruction-fetch port and a load/store port onto one bus.
// The data port wins arbitration; byte lanes are little-endian and all bus outputs are registered.
module avalon_bus_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  input  logic        data_sign,
  input  logic [31:0] data_wdata,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        addr_error,
  output logic        busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StCapt = 2'd2;
  localparam logic [1:0] StWr   = 2'd3;

  logic [1:0] state_q;
  logic       is_fetch_q;
  logic [1:0] size_q;
  logic       sign_q;
  logic [1:0] lane_q;

  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        misaligned;
  logic [31:0] load_ext;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;

  // Fetches are always word-aligned; the low address bits carry no information.
  logic unused_fetch_lsb;
  assign unused_fetch_lsb = ^fetch_addr[1:0];

  assign busy = (state_q != StIdle);

  always_comb begin
    req_be     = 4'b1111;
    req_wdata  = data_wdata;
    misaligned = 1'b0;
    unique case (data_size)
      2'b00: begin
        req_be    = 4'b0001 << data_addr[1:0];
        req_wdata = {4{data_wdata[7:0]}};
      end
      2'b01: begin
        req_be     = data_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata  = {2{data_wdata[15:0]}};
        misaligned = data_addr[0];
      end
      default: misaligned = (data_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    rd_shift = readdata >> {lane_q, 3'b000};
    rd_half  = lane_q[1] ? readdata[31:16] : readdata[15:0];
    load_ext = readdata;
    unique case (size_q)
      2'b00:   load_ext = {{24{sign_q & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_ext = {{16{sign_q & rd_half[15]}}, rd_half};
      default: load_ext = readdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      is_fetch_q  <= 1'b0;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      lane_q      <= 2'b00;
      address     <= 32'h0;
      read        <= 1'b0;
      write       <= 1'b0;
      byteenable  <= 4'h0;
      writedata   <= 32'h0;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      data_rdata  <= 32'h0;
      data_valid  <= 1'b0;
      addr_error  <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      data_valid  <= 1'b0;
      addr_error  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (data_req) begin
            if (misaligned) begin
              addr_error <= 1'b1;
            end else begin
              address    <= {data_addr[31:2], 2'b00};
              byteenable <= req_be;
              is_fetch_q <= 1'b0;
              size_q     <= data_size;
              sign_q     <= data_sign;
              lane_q     <= data_addr[1:0];
              if (data_we) begin
                writedata <= req_wdata;
                write     <= 1'b1;
                state_q   <= StWr;
              end else begin
                read    <= 1'b1;
                state_q <= StRd;
              end
            end
          end else if (fetch_req) begin
            address    <= {fetch_addr[31:2], 2'b00};
            byteenable <= 4'b1111;
            is_fetch_q <= 1'b1;
            read       <= 1'b1;
            state_q    <= StRd;
          end
        end
        StRd: begin
          if (!waitrequest) begin
            read    <= 1'b0;
            state_q <= StCapt;
          end
        end
        // Slave returns readdata one cycle after the read is accepted.
        StCapt: begin
          state_q <= StIdle;
          if (is_fetch_q) begin
            instr       <= readdata;
            instr_valid <= 1'b1;
          end else begin
            data_rdata <= load_ext;
            data_valid <= 1'b1;
          end
        end
        StWr: begin
          if (!waitrequest) begin
            write      <= 1'b0;
            data_valid <= 1'b1;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_bus_ctrl.sv
// Directed self-checking bench for avalon_bus_ctrl; outputs are sampled 1 ns after each rising edge.
module tb_avalon_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_sign;
  logic [31:0] data_wdata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        addr_error;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  avalon_bus_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_addr   (data_addr),
    .data_size   (data_size),
    .data_sign   (data_sign),
    .data_wdata  (data_wdata),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .address     (address),
    .read        (read),
    .write       (write),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .data_rdata  (data_rdata),
    .data_valid  (data_valid),
    .addr_error  (addr_error),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load with no wait states: accept edge, release edge, capture edge.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] rd, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    data_req = 1'b1; data_we = 1'b0; data_addr = addr; data_size = size; data_sign = sgn;
    waitrequest = 1'b0;
    step();
    check({tag, " read"}, {31'b0, read}, 32'd1);
    check({tag, " addr"}, address, exp_addr);
    check({tag, " be"}, {28'b0, byteenable}, {28'b0, exp_be});
    data_req = 1'b0;
    step();
    check({tag, " read drop"}, {31'b0, read}, 32'd0);
    readdata = rd;
    step();
    check({tag, " valid"}, {31'b0, data_valid}, 32'd1);
    check({tag, " rdata"}, data_rdata, exp_data);
    readdata = 32'h0;
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] wd, input int waits, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    data_req = 1'b1; data_we = 1'b1; data_addr = addr; data_size = size; data_wdata = wd;
    waitrequest = (waits > 0);
    step();
    data_req = 1'b0;
    check({tag, " write"}, {31'b0, write}, 32'd1);
    check({tag, " addr"}, address, exp_addr);
    check({tag, " be"}, {28'b0, byteenable}, {28'b0, exp_be});
    check({tag, " wdata"}, writedata, exp_wd);
    for (int i = 0; i < waits; i++) begin
      step();
      check({tag, " write held"}, {31'b0, write}, 32'd1);
      check({tag, " addr held"}, address, exp_addr);
      check({tag, " no early valid"}, {31'b0, data_valid}, 32'd0);
    end
    waitrequest = 1'b0;
    step();
    check({tag, " write drop"}, {31'b0, write}, 32'd0);
    check({tag, " valid"}, {31'b0, data_valid}, 32'd1);
    check({tag, " idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = 32'h0; data_req = 1'b0; data_we = 1'b0;
    data_addr = 32'h0; data_size = 2'b00; data_sign = 1'b0; data_wdata = 32'h0;
    waitrequest = 1'b0; readdata = 32'h0;
    step();
    step();
    check("rst read", {31'b0, read}, 32'd0);
    check("rst write", {31'b0, write}, 32'd0);
    check("rst busy", {31'b0, busy}, 32'd0);
    check("rst addr", address, 32'h0);
    check("rst be", {28'b0, byteenable}, 32'h0);
    check("rst instr", instr, 32'h0);
    check("rst rdata", data_rdata, 32'h0);
    reset = 1'b0;
    step();

    // Instruction fetch, no wait states.
    fetch_req = 1'b1; fetch_addr = 32'hBFC0_0000;
    step();
    fetch_req = 1'b0;
    check("fetch read", {31'b0, read}, 32'd1);
    check("fetch addr", address, 32'hBFC0_0000);
    check("fetch be", {28'b0, byteenable}, 32'hF);
    check("fetch busy", {31'b0, busy}, 32'd1);
    step();
    check("fetch read 1cyc", {31'b0, read}, 32'd0);
    check("fetch no early valid", {31'b0, instr_valid}, 32'd0);
    readdata = 32'h2402_0005;
    step();
    readdata = 32'h0;
    check("fetch valid", {31'b0, instr_valid}, 32'd1);
    check("fetch instr", instr, 32'h2402_0005);
    step();
    check("fetch valid pulse", {31'b0, instr_valid}, 32'd0);
    check("fetch instr hold", instr, 32'h2402_0005);

    // Loads across sizes, lanes and extension modes.
    do_load("lb s", 32'h0000_1003, 2'b00, 1'b1, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80);
    do_load("lb u", 32'h0000_1003, 2'b00, 1'b0, 32'h80FF_1234, 32'h0000_1000, 4'b1000, 32'h0000_0080);
    do_load("lb l1", 32'h0000_1001, 2'b00, 1'b1, 32'h80FF_1234, 32'h0000_1000, 4'b0010, 32'h0000_0012);
    do_load("lh s", 32'h0000_1002, 2'b01, 1'b1, 32'h80FF_1234, 32'h0000_1000, 4'b1100, 32'hFFFF_80FF);
    do_load("lh u", 32'h0000_1000, 2'b01, 1'b0, 32'h80FF_9234, 32'h0000_1000, 4'b0011, 32'h0000_9234);
    do_load("lw", 32'h0000_1004, 2'b10, 1'b1, 32'h80FF_1234, 32'h0000_1004, 4'b1111, 32'h80FF_1234);
    do_load("lw sz11", 32'h0000_1008, 2'b11, 1'b0, 32'hCAFE_F00D, 32'h0000_1008, 4'b1111, 32'hCAFE_F00D);

    // Stores, including three wait-state cycles.
    do_store("sh wait", 32'h0000_2002, 2'b01, 32'h0000_BEEF, 3, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
    do_store("sb", 32'h0000_3001, 2'b00, 32'h0000_00A5, 0, 32'h0000_3000, 4'b0010, 32'hA5A5_A5A5);
    do_store("sw", 32'h0000_4000, 2'b10, 32'h1234_5678, 1, 32'h0000_4000, 4'b1111, 32'h1234_5678);

    // Simultaneous requests: the load wins, the held fetch goes next.
    fetch_req = 1'b1; fetch_addr = 32'h0000_0100;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0010; data_size = 2'b10;
    step();
    data_req = 1'b0;
    check("arb addr", address, 32'h0000_0010);
    check("arb read", {31'b0, read}, 32'd1);
    step();
    check("arb addr stable", address, 32'h0000_0010);
    readdata = 32'h5555_AAAA;
    step();
    readdata = 32'h0;
    check("arb load valid", {31'b0, data_valid}, 32'd1);
    check("arb no instr", {31'b0, instr_valid}, 32'd0);
    check("arb load data", data_rdata, 32'h5555_AAAA);
    step();
    fetch_req = 1'b0;
    check("arb fetch addr", address, 32'h0000_0100);
    check("arb fetch read", {31'b0, read}, 32'd1);
    step();
    readdata = 32'h0000_0013;
    step();
    readdata = 32'h0;
    check("arb fetch valid", {31'b0, instr_valid}, 32'd1);
    check("arb fetch instr", instr, 32'h0000_0013);
    check("arb rdata hold", data_rdata, 32'h5555_AAAA);

    // Misaligned accesses raise addr_error and start nothing.
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_0006; data_size = 2'b10;
    step();
    data_req = 1'b0;
    check("mis lw read", {31'b0, read}, 32'd0);
    check("mis lw err", {31'b0, addr_error}, 32'd1);
    check("mis lw busy", {31'b0, busy}, 32'd0);
    step();
    check("mis lw err pulse", {31'b0, addr_error}, 32'd0);
    check("mis lw no valid", {31'b0, data_valid}, 32'd0);
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h0000_0011; data_size = 2'b01;
    step();
    data_req = 1'b0;
    check("mis sh write", {31'b0, write}, 32'd0);
    check("mis sh err", {31'b0, addr_error}, 32'd1);
    step();
    check("mis sh no valid", {31'b0, data_valid}, 32'd0);

    // Reset while a read is stalled.
    fetch_req = 1'b1; fetch_addr = 32'h0000_0200; waitrequest = 1'b1;
    step();
    fetch_req = 1'b0;
    check("rrd read", {31'b0, read}, 32'd1);
    step();
    check("rrd read held", {31'b0, read}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; waitrequest = 1'b0; readdata = 32'hDEAD_BEEF;
    check("rrd read drop", {31'b0, read}, 32'd0);
    check("rrd busy", {31'b0, busy}, 32'd0);
    check("rrd instr clr", instr, 32'h0);
    step();
    check("rrd no valid", {31'b0, instr_valid}, 32'd0);
    step();
    check("rrd no valid 2", {31'b0, instr_valid}, 32'd0);
    check("rrd instr kept", instr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
